axis_pkt_rr_arbiter: RTL
========================

Name: axis_pkt_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one downstream AXI-Stream slave among NUM_INPUTS upstream masters.
- Inputs use the packed multi-stream bus convention: stream i occupies tdata[DWIDTH*i +: DWIDTH] and bit i of tvalid, tlast and tready.
- A grant is held from the first word of a packet through its tlast transfer, so packets are never interleaved.
- Sits in front of shared resources such as a single CHDR crossbar port, a DMA engine or a shared DSP block.

Parameters:
- DWIDTH, 32, data width per stream.
- NUM_INPUTS, 4, number of requesting streams (>=1).
- SEL_W, max(1, clog2(NUM_INPUTS)), width of the grant index; derived, do not override.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new grant is issued; a packet already in flight completes.
- i_tdata  in  NUM_INPUTS*DWIDTH  packed input data.
- i_tvalid  in  NUM_INPUTS  per-stream valid.
- i_tlast  in  NUM_INPUTS  per-stream last.
- i_tready  out  NUM_INPUTS  per-stream ready.
- o_tdata  out  DWIDTH  output data.
- o_tvalid  out  1  output valid.
- o_tlast  out  1  output last.
- o_tready  in  1  downstream ready.
- o_tdest  out  SEL_W  index of the granted input for the current packet.
- busy  out  1  high while in PASS.
- pkt_count  out  32  count of packets forwarded; wraps at 2^32.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values:
  - state=IDLE, grant=0, last_ptr=NUM_INPUTS-1, so input 0 has first priority.
  - pkt_count=0.
  - All i_tready=0, o_tvalid=0.
  - o_tdest=0, busy=0.
- Reset asserted mid-packet aborts the packet immediately. Downstream sees a truncated packet, which is acceptable; upstream state is the sources' responsibility.
- State IDLE:
  - o_tvalid=0 and all i_tready=0.
  - If enable=1 and any i_tvalid=1, pick the first i with i_tvalid[i]=1, scanning cyclically from last_ptr+1.
  - Register grant=i and move to PASS on the next edge. This gives one cycle of arbitration latency, and tvalid is only sampled.
  - If no request, or enable=0, remain in IDLE.
- State PASS (combinational datapath, zero latency):
  - o_tdata=i_tdata[grant], o_tvalid=i_tvalid[grant], o_tlast=i_tlast[grant].
  - i_tready[grant]=o_tready; all other i_tready=0. o_tdest=grant; busy=1.
  - On a transfer with o_tvalid & o_tready & o_tlast: last_ptr<=grant, pkt_count<=pkt_count+1, go to IDLE.
  - There is one bubble cycle between consecutive packets (IDLE re-arbitration).
  - Non-last transfers and stalls (o_tready=0, or i_tvalid[grant]=0) stay in PASS, with grant unchanged.
  - enable changes are ignored in PASS.
- o_tdest holds its last value in IDLE; it is only meaningful while o_tvalid=1.
- No combinational path from o_tready to o_tvalid.
- Fairness:
  - After input k finishes a packet, every other input with valid asserted in the next IDLE cycle is served before k is served again.
  - Worst-case wait is (NUM_INPUTS-1) packets.
- Single-word packets (tlast on the first word) are legal: PASS lasts one transfer.
- NUM_INPUTS=1 degenerates to a pass-through with a one-cycle gap per packet; grant is always 0.
- Inputs must obey AXI-Stream: tvalid may not drop before the handshake. This is not checked.

Test Plan:
- Reset then idle: reset_n low 3 cycles, inputs idle → o_tvalid=0, i_tready=0000, pkt_count=0, o_tdest=0.
- Single source: input 2 pushes a 4-word ramp (0x10, 0x11, 0x12, 0x13), o_tready=1 → output word 0 appears the cycle after i_tvalid rises, then words 1–3 back-to-back, o_tdest=2, o_tlast on 0x13 only, pkt_count=1.
- Round robin under contention: all 4 inputs continuously push 3-word packets tagged with the input index.
  - Required output packet order: 0,1,2,3,0,1,…
  - No interleaving within a packet.
  - One idle cycle between packets.
  - After 8 packets, pkt_count=8.
- Backpressure: random o_tready (50%) with input 1 pushing a 16-word random packet and input 3 requesting.
  - All 16 words arrive in order with tlast on word 16.
  - Input 3 is not granted until after word 16 transfers.
  - i_tready[3] stays 0 throughout.
- Enable gating: enable=0 while input 0 requests → no grant for 10 cycles; raise enable → packet forwarded. Dropping enable mid-packet still lets that packet complete.
- Async reset mid-packet: assert reset_n low between clock edges during word 2 of 5 → outputs clear immediately, without waiting for a clock. After release, input 0 has priority over simultaneous requests on inputs 0 and 2.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter.sv
// axis_pkt_rr_arbiter: packet-level round-robin mux of NUM_INPUTS AXI-Stream sources onto one sink
module axis_pkt_rr_arbiter #(
  parameter int DWIDTH = 32,
  parameter int NUM_INPUTS = 4,
  localparam int SEL_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_INPUTS*DWIDTH-1:0] i_tdata,
  input  logic [NUM_INPUTS-1:0]        i_tvalid,
  input  logic [NUM_INPUTS-1:0]        i_tlast,
  output logic [NUM_INPUTS-1:0]        i_tready,
  output logic [DWIDTH-1:0]            o_tdata,
  output logic                         o_tvalid,
  output logic                         o_tlast,
  input  logic                         o_tready,
  output logic [SEL_W-1:0]             o_tdest,
  output logic                         busy,
  output logic [31:0]                  pkt_count
);
  typedef enum logic {IDLE, PASS} state_t;
  state_t state;
  logic [SEL_W-1:0] grant, last_ptr, next_sel;
  logic found, pass;
  assign pass = state == PASS;
  // Scan downwards so the candidate closest after last_ptr is written last and wins.
  always_comb begin
    next_sel = grant;
    found = 1'b0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      if (i_tvalid[(int'(last_ptr) + k) % NUM_INPUTS]) begin
        found = 1'b1;
        next_sel = SEL_W'((int'(last_ptr) + k) % NUM_INPUTS);
      end
    end
  end
  always_comb begin
    i_tready = '0;
    if (pass) i_tready[grant] = o_tready;
  end
  assign o_tdata = i_tdata[int'(grant)*DWIDTH +: DWIDTH];
  assign o_tvalid = pass && i_tvalid[grant];
  assign o_tlast = pass && i_tlast[grant];
  assign o_tdest = grant;
  assign busy = pass;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_ptr <= SEL_W'(NUM_INPUTS - 1);
      pkt_count <= '0;
    end else if (!pass) begin
      if (enable && found) begin
        grant <= next_sel;
        state <= PASS;
      end
    end else if (o_tvalid && o_tready && o_tlast) begin
      last_ptr <= grant;
      pkt_count <= pkt_count + 32'd1;
      state <= IDLE;
    end
  end
endmodule
